// File: rtl/xoro_periph_pkg.sv
// Shared definitions for the xoro peripheral slice: register map, ADC command
// layout, sample width and the scanner state encoding.
package xoro_periph_pkg;

  localparam int unsigned SPI_W      = 16;
  localparam int unsigned BUS_W      = 32;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned REG_IDX_W  = 4;
  localparam int unsigned SAMPLE_W   = 12;
  localparam int unsigned MAX_CH     = 8;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned CMD_CH_LSB = 11;
  localparam int unsigned CMD_CH_MSB = 13;
  localparam int unsigned SCAN_CNT_W = 16;
  localparam int unsigned SCAN_CNT_LSB = 8;

  localparam logic [REG_IDX_W-1:0] REG_RESULT0 = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG_CTRL    = 4'd8;
  localparam logic [REG_IDX_W-1:0] REG_STATUS  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIG      = 2'd1,
    ST_DONE_WAIT = 2'd2,
    ST_STORE     = 2'd3
  } scan_state_e;

  // Sample write from the scanner FSM into the result bank
  typedef struct packed {
    logic                en;
    logic [CH_W-1:0]     slot;
    logic [SAMPLE_W-1:0] data;
  } store_t;

  function automatic logic [SPI_W-1:0] adc_cmd(input logic [CH_W-1:0] ch);
    logic [SPI_W-1:0] cmd;
    cmd = '0;
    cmd[CMD_CH_MSB:CMD_CH_LSB] = ch;
    return cmd;
  endfunction

endpackage

// File: rtl/adc_regfile.sv
// Bus-facing register bank of the ADC scanner: RESULT[0..7], CTRL, STATUS,
// with fresh-on-store / clear-on-read and sticky timeout rules.
module adc_regfile
  import xoro_periph_pkg::*;
(
  input  logic              clk,
  input  logic              resn,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [BUS_W-1:0]  mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic [BUS_W-1:0]  mem_rdata,
  output logic              mem_ready,
  input  store_t            store,
  input  logic              scan_done,
  input  logic              timeout_set,
  input  logic              busy,
  output logic              enable
);

  logic [MAX_CH-1:0][SAMPLE_W-1:0] sample;
  logic [MAX_CH-1:0]               fresh;
  logic                            timeout_flag;
  logic [SCAN_CNT_W-1:0]           scan_cnt;

  logic [REG_IDX_W-1:0] idx_c;
  logic [CH_W-1:0]      slot_c;
  logic                 access_c;
  logic                 rd_c;
  logic                 wr_c;
  logic                 res_sel_c;
  logic [BUS_W-1:0]     rd_word_c;
  logic                 unused_bits;

  // One access per request: ready itself blocks a second accept while valid lingers
  assign access_c  = mem_valid && !mem_ready;
  assign rd_c      = access_c && (mem_wstrb == '0);
  assign wr_c      = access_c && (mem_wstrb != '0);
  assign idx_c     = mem_addr[ADDR_W-1:2];
  assign slot_c    = idx_c[CH_W-1:0];
  assign res_sel_c = (idx_c[REG_IDX_W-1:CH_W] == REG_RESULT0[REG_IDX_W-1:CH_W]);

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[BUS_W-1:2]};

  always_comb begin
    rd_word_c = '0;
    if (res_sel_c) begin
      rd_word_c[BUS_W-1]      = fresh[slot_c];
      rd_word_c[SAMPLE_W-1:0] = sample[slot_c];
    end else if (idx_c == REG_CTRL) begin
      rd_word_c[0] = enable;
    end else if (idx_c == REG_STATUS) begin
      rd_word_c[0] = busy;
      rd_word_c[1] = timeout_flag;
      rd_word_c[SCAN_CNT_LSB +: SCAN_CNT_W] = scan_cnt;
    end
  end

  // Later assignments win: a store beats a same-cycle read-clear, a timeout beats a W1C
  always_ff @(posedge clk) begin
    if (!resn) begin
      mem_ready    <= 1'b0;
      mem_rdata    <= '0;
      sample       <= '0;
      fresh        <= '0;
      enable       <= 1'b0;
      timeout_flag <= 1'b0;
      scan_cnt     <= '0;
    end else begin
      mem_ready <= access_c;
      mem_rdata <= rd_c ? rd_word_c : '0;
      if (rd_c && res_sel_c) begin
        fresh[slot_c] <= 1'b0;
      end
      if (store.en) begin
        sample[store.slot] <= store.data;
        fresh[store.slot]  <= 1'b1;
      end
      if (wr_c && mem_wstrb[0]) begin
        if (idx_c == REG_CTRL) begin
          enable <= mem_wdata[0];
        end
        if ((idx_c == REG_STATUS) && mem_wdata[1]) begin
          timeout_flag <= 1'b0;
        end
      end
      if (timeout_set) begin
        timeout_flag <= 1'b1;
      end
      if (scan_done) begin
        scan_cnt <= scan_cnt + SCAN_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_scanner.sv
// Autonomous ADC channel sequencer: drives the spi master handshake for
// NUM_CH+1 pipelined frames per scan and files samples into adc_regfile.
module adc_scanner
  import xoro_periph_pkg::*;
#(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned PERIOD  = 100000,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              resn,
  output logic              spi_trig,
  output logic [SPI_W-1:0]  spi_wrData,
  input  logic [SPI_W-1:0]  spi_rdData,
  input  logic              spi_done,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [BUS_W-1:0]  mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic [BUS_W-1:0]  mem_rdata,
  output logic              mem_ready,
  output logic              irq
);

  localparam int unsigned IDX_W  = $clog2(NUM_CH + 1);
  localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_CH);
  localparam logic [PCNT_W-1:0] PCNT_RELOAD = PCNT_W'(PERIOD - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(TIMEOUT - 1);

  scan_state_e       state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;

  logic              trig_nxt;
  logic [SPI_W-1:0]  wrdata_nxt;
  logic              irq_nxt;
  logic [CH_W-1:0]   ch_nxt_c;
  logic              expired_c;
  logic              timeout_c;
  logic              scan_done_c;
  logic              busy_c;
  logic              enable;
  store_t            store_c;
  logic              unused_rd;

  assign expired_c = (tcnt == TCNT_LAST);
  assign busy_c    = (state != ST_IDLE);
  assign unused_rd = ^spi_rdData[SPI_W-1:SAMPLE_W];

  always_ff @(posedge clk) begin
    if (!resn) begin
      state      <= ST_IDLE;
      idx        <= '0;
      tcnt       <= '0;
      pcnt       <= '0;
      spi_trig   <= 1'b0;
      spi_wrData <= '0;
      irq        <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      tcnt       <= tcnt_nxt;
      pcnt       <= pcnt_nxt;
      spi_trig   <= trig_nxt;
      spi_wrData <= wrdata_nxt;
      irq        <= irq_nxt;
    end
  end

  // Next state; the period counter runs start-to-start and parks at zero
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tcnt_nxt  = tcnt;
    pcnt_nxt  = pcnt;
    if (enable && (pcnt != '0)) begin
      pcnt_nxt = pcnt - PCNT_W'(1);
    end
    unique case (state)
      ST_IDLE: begin
        if (enable && (pcnt == '0)) begin
          state_nxt = ST_TRIG;
          idx_nxt   = '0;
          tcnt_nxt  = '0;
          pcnt_nxt  = PCNT_RELOAD;
        end
      end
      ST_TRIG: begin
        if (!spi_done) begin
          state_nxt = ST_DONE_WAIT;
          tcnt_nxt  = '0;
        end else if (expired_c) begin
          state_nxt = ST_IDLE;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end
      ST_DONE_WAIT: begin
        if (spi_done) begin
          state_nxt = ST_STORE;
        end else if (expired_c) begin
          state_nxt = ST_IDLE;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end
      ST_STORE: begin
        if (idx == IDX_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_TRIG;
          idx_nxt   = idx + IDX_W'(1);
          tcnt_nxt  = '0;
        end
      end
    endcase
  end

  // Outputs; the command word latches on TRIG entry and holds through DONE_WAIT
  always_comb begin
    trig_nxt    = (state_nxt == ST_TRIG);
    wrdata_nxt  = spi_wrData;
    ch_nxt_c    = (idx_nxt == IDX_LAST) ? '0 : CH_W'(idx_nxt);
    scan_done_c = (state == ST_STORE) && (idx == IDX_LAST);
    irq_nxt     = scan_done_c;
    timeout_c   = expired_c && (((state == ST_TRIG) && spi_done) ||
                                ((state == ST_DONE_WAIT) && !spi_done));
    store_c     = '0;
    if ((state_nxt == ST_TRIG) && (state != ST_TRIG)) begin
      wrdata_nxt = adc_cmd(ch_nxt_c);
    end
    if ((state == ST_STORE) && (idx != '0)) begin
      store_c.en   = 1'b1;
      store_c.slot = CH_W'(idx - IDX_W'(1));
      store_c.data = spi_rdData[SAMPLE_W-1:0];
    end
  end

  adc_regfile u_regfile (
    .clk         (clk),
    .resn        (resn),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .store       (store_c),
    .scan_done   (scan_done_c),
    .timeout_set (timeout_c),
    .busy        (busy_c),
    .enable      (enable)
  );

endmodule

// File: tb/tb_adc_scanner.sv
// Bench for adc_scanner: behavioural pipelined ADC behind a randomized spi
// handshake, bus reads checked against expectations derived from channel rules.
module tb_adc_scanner;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned PERIOD  = 400;
  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        resn;
  logic        spi_trig;
  logic [15:0] spi_wrData;
  logic [15:0] spi_rdData;
  logic        spi_done;
  logic        mem_valid;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int trig_rises = 0;
  int irq_rises = 0;
  int irq_highs = 0;
  logic trig_q = 1'b0;
  logic irq_q = 1'b0;
  bit stuck = 1'b0;
  logic [15:0] wr_log[$];
  int unsigned prev_ch = 0;

  adc_scanner #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resn(resn), .spi_trig(spi_trig), .spi_wrData(spi_wrData),
    .spi_rdData(spi_rdData), .spi_done(spi_done), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Edge counters on trig and irq
  initial forever begin
    @(negedge clk);
    if (spi_trig && !trig_q) trig_rises++;
    if (irq && !irq_q) irq_rises++;
    if (irq) irq_highs++;
    trig_q = spi_trig;
    irq_q  = irq;
  end

  // spi + ADC model: frame k returns channel of frame k-1 as (ch+1)*0x111, junk upper nibble
  initial begin
    logic [2:0] ch;
    spi_done = 1'b1;
    spi_rdData = 16'h0;
    forever begin
      @(negedge clk);
      if (spi_trig && !stuck) begin
        ch = spi_wrData[13:11];
        wr_log.push_back(spi_wrData);
        repeat ($urandom_range(5, 0)) @(negedge clk);
        spi_done = 1'b0;
        repeat ($urandom_range(20, 6)) @(negedge clk);
        spi_rdData = {4'($urandom), 12'((prev_ch + 1) * 32'h111)};
        prev_ch = 32'(ch);
        spi_done = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end

  task automatic bus(input logic [3:0] idx, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rdata, output int lat, output logic ready_after);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = {idx, 2'b00};
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 8);
    checks++;
    if (!mem_ready) begin
      errors++;
      $display("FAIL bus_ack idx=%0d: got no mem_ready expected ack within 8 cycles", idx);
    end
    rdata = mem_rdata;
    @(negedge clk);
    ready_after = mem_ready;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [3:0] idx, output logic [31:0] d);
    int lat;
    logic ra;
    bus(idx, 32'h0, 4'h0, d, lat, ra);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] v);
    logic [31:0] d;
    int lat;
    logic ra;
    bus(idx, v, 4'hF, d, lat, ra);
  endtask

  task automatic wait_irq(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (irq_rises > base) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resn = 1'b0;
    mem_valid = 1'b0;
    mem_addr = 6'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if (spi_trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b expected 0", spi_trig); end
    checks++; if (spi_wrData !== 16'h0) begin errors++; $display("FAIL reset_wrdata: got %h expected 0000", spi_wrData); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", mem_ready); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    resn = 1'b1;
    rd(4'd8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    rd(4'd9, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", d); end
    rd(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_result0: got %h expected 0", d); end
  endtask

  task automatic test_full_scan();
    logic [31:0] d, e;
    logic [15:0] c;
    int bt, bi, bh;
    bit ok;
    wr_log.delete();
    bt = trig_rises; bi = irq_rises; bh = irq_highs;
    wr(4'd8, 32'h1);
    wait_irq(bi, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_irq_wait: got no irq expected irq within 3000 cycles"); end
    wr(4'd8, 32'h0);
    repeat (5) @(negedge clk);
    checks++; if (trig_rises - bt != 9) begin errors++; $display("FAIL scan_trig_edges: got %0d expected 9", trig_rises - bt); end
    checks++; if (irq_rises - bi != 1) begin errors++; $display("FAIL scan_irq_count: got %0d expected 1", irq_rises - bi); end
    checks++; if (irq_highs - bh != 1) begin errors++; $display("FAIL scan_irq_width: got %0d expected 1", irq_highs - bh); end
    checks++; if (wr_log.size() != 9) begin errors++; $display("FAIL scan_frames: got %0d expected 9", wr_log.size()); end
    for (int j = 0; j < wr_log.size(); j++) begin
      c = 16'((j % NUM_CH) * 2048);
      checks++; if (wr_log[j] !== c) begin errors++; $display("FAIL scan_cmd%0d: got %h expected %h", j, wr_log[j], c); end
    end
    if (wr_log.size() > 3) begin
      checks++; if (wr_log[3] !== 16'h1800) begin errors++; $display("FAIL scan_frame3: got %h expected 1800", wr_log[3]); end
    end
    for (int n = 0; n < 8; n++) begin
      rd(4'(n), d);
      e = 32'h8000_0000 | 32'((n + 1) * 32'h111);
      checks++; if (d !== e) begin errors++; $display("FAIL scan_result%0d: got %h expected %h", n, d, e); end
    end
    rd(4'd9, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL scan_status: got %h expected 00000100", d); end
  endtask

  task automatic test_read_twice();
    logic [31:0] d;
    bit ok;
    wr(4'd8, 32'h1);
    wait_irq(irq_rises, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rt_irq_wait: got no irq expected irq within 3000 cycles"); end
    wr(4'd8, 32'h0);
    rd(4'd2, d);
    checks++; if (d !== 32'h8000_0333) begin errors++; $display("FAIL rt_first: got %h expected 80000333", d); end
    rd(4'd2, d);
    checks++; if (d !== 32'h0000_0333) begin errors++; $display("FAIL rt_second: got %h expected 00000333", d); end
    rd(4'd9, d);
    checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL rt_status: got %h expected 00000200", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int bi, n, hi;
    stuck = 1'b1;
    bi = irq_rises;
    wr(4'd8, 32'h1);
    n = 0;
    while (!spi_trig && n < 1000) begin @(negedge clk); n++; end
    checks++; if (!spi_trig) begin errors++; $display("FAIL to_trig_wait: got no trig expected trig within 1000 cycles"); end
    hi = 0;
    while (spi_trig && hi < 200) begin hi++; @(negedge clk); end
    wr(4'd8, 32'h0);
    checks++; if (hi != TIMEOUT) begin errors++; $display("FAIL to_trig_len: got %0d expected %0d", hi, TIMEOUT); end
    checks++; if (irq_rises != bi) begin errors++; $display("FAIL to_no_irq: got %0d expected 0", irq_rises - bi); end
    rd(4'd9, d);
    checks++; if (d !== 32'h0000_0202) begin errors++; $display("FAIL to_status_set: got %h expected 00000202", d); end
    wr(4'd9, 32'h2);
    rd(4'd9, d);
    checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL to_status_clr: got %h expected 00000200", d); end
    stuck = 1'b0;
  endtask

  task automatic test_disable_mid();
    logic [31:0] d, e;
    int bt, bi, n;
    bit ok;
    wr_log.delete();
    bt = trig_rises; bi = irq_rises;
    wr(4'd8, 32'h1);
    n = 0;
    while (wr_log.size() < 5 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (wr_log.size() < 5) begin errors++; $display("FAIL dm_frame4: got %0d frames expected 5", wr_log.size()); end
    wr(4'd8, 32'h0);
    wait_irq(bi, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dm_irq: got no irq expected irq within 3000 cycles"); end
    repeat (3) @(negedge clk);
    checks++; if (trig_rises - bt != 9) begin errors++; $display("FAIL dm_trig_edges: got %0d expected 9", trig_rises - bt); end
    for (int k = 0; k < 8; k++) begin
      rd(4'(k), d);
      e = 32'h8000_0000 | 32'((k + 1) * 32'h111);
      checks++; if (d !== e) begin errors++; $display("FAIL dm_result%0d: got %h expected %h", k, d, e); end
    end
    bt = trig_rises;
    repeat (2 * PERIOD) @(negedge clk);
    checks++; if (trig_rises != bt) begin errors++; $display("FAIL dm_quiet: got %0d trig edges expected 0", trig_rises - bt); end
  endtask

  task automatic test_bus_misc();
    logic [31:0] d, v;
    logic [3:0] idx, st;
    int lat;
    logic ra;
    bus(4'd12, 32'h0, 4'h0, d, lat, ra);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL bm_rd12: got %h expected 0", d); end
    checks++; if (lat != 1) begin errors++; $display("FAIL bm_rd_lat: got %0d expected 1", lat); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL bm_rd_pulse: got %b expected 0", ra); end
    bus(4'd8, 32'h1, 4'hF, d, lat, ra);
    checks++; if (lat != 1) begin errors++; $display("FAIL bm_wr_lat: got %0d expected 1", lat); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL bm_wr_pulse: got %b expected 0", ra); end
    rd(4'd8, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL bm_ctrl: got %h expected 1", d); end
    wr(4'd8, 32'h0);
    for (int k = 0; k < 4; k++) begin
      idx = 4'(10 + $urandom_range(5, 0));
      v   = $urandom;
      st  = 4'($urandom_range(15, 1));
      bus(idx, v, st, d, lat, ra);
      rd(idx, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL bm_reserved%0d: got %h expected 0", idx, d); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n, bt;
    wr(4'd8, 32'h1);
    n = 0;
    while (spi_done && n < 2000) begin @(negedge clk); n++; end
    checks++; if (spi_done) begin errors++; $display("FAIL rm_frame_wait: got done high expected a frame within 2000 cycles"); end
    repeat (2) @(negedge clk);
    resn = 1'b0;
    @(negedge clk);
    checks++; if (spi_trig !== 1'b0) begin errors++; $display("FAIL rm_trig: got %b expected 0", spi_trig); end
    resn = 1'b1;
    rd(4'd8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_ctrl: got %h expected 0", d); end
    rd(4'd9, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_status: got %h expected 0", d); end
    for (int k = 0; k < 8; k++) begin
      rd(4'(k), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_result%0d: got %h expected 0", k, d); end
    end
    bt = trig_rises;
    repeat (2 * PERIOD) @(negedge clk);
    checks++; if (trig_rises != bt) begin errors++; $display("FAIL rm_quiet: got %0d trig edges expected 0", trig_rises - bt); end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_read_twice();
    test_timeout();
    test_disable_mid();
    test_bus_misc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_scanner.md
# adc_scanner

Autonomous ADC channel sequencer that sits directly upstream of the `spi` master. It builds 16-bit ADC128S022-style command frames, pulses `trig`, waits for `done`, and files each returned 12-bit conversion into a per-channel result register. A CPU reads the results over the memory bus without touching the SPI handshake.

## Interface
- `NUM_CH`, 8: channels scanned, 1..8.
- `PERIOD`, 100000: `clk` cycles between scan starts, measured start to start.
- `TIMEOUT`, 4096: maximum `clk` cycles allowed per handshake phase.

- `clk` in 1: system clock.
- `resn` in 1: reset. Synchronous, active-low.
- `spi_trig` out 1: to `spi.trig`.
- `spi_wrData` out 16: to `spi.wrData`.
- `spi_rdData` in 16: from `spi.rdData`.
- `spi_done` in 1: from `spi.done`. High when idle, low while a frame is in flight.
- `mem_valid` in 1: bus request, pre-decoded for this block.
- `mem_addr` in 6: byte address; bits [5:2] are used.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: write strobes; zero means read.
- `mem_rdata` out 32: read data.
- `mem_ready` out 1: bus acknowledge.
- `irq` out 1: scan-complete pulse.

## Operation
- Reset values:
  - `spi_trig`=0, `spi_wrData`=0, `mem_ready`=0, `mem_rdata`=0, `irq`=0.
  - All result registers 0.
  - CTRL=0, STATUS=0.
  - FSM=IDLE, period counter=0.
- Register map, word index `mem_addr[5:2]`:
  - 0..7 RESULT[n]: bit 31 = fresh (set on store, cleared by a read of that word); [11:0] = sample. Read-only.
  - 8 CTRL: bit 0 = enable. Read/write.
  - 9 STATUS: bit 0 = busy, bit 1 = timeout (sticky; write 1 clears), [23:8] = scan count (wraps). Read-only except bit 1.
  - Other indices read 0; writes to them are ignored.
- Command word: `spi_wrData` = {2'b00, ch[2:0], 11'b0}. It is held stable from TRIG until DONE_WAIT exits.
- Pipeline offset: frame k returns the conversion of the channel addressed in frame k-1.
  - A scan issues NUM_CH+1 frames. Frame j addresses channel j mod NUM_CH.
  - Frame 0's data is discarded. The data of frame j (j≥1) is stored to RESULT[j-1].
- FSM:
  - IDLE: when enable=1 and the period counter reaches 0 → TRIG, with frame index=0 and counter reloaded to PERIOD-1. The counter decrements every cycle while enable=1.
  - TRIG: `spi_trig`=1 until `spi_done`=0 is sampled → DONE_WAIT, with `spi_trig`=0 in that same cycle.
  - DONE_WAIT: wait for `spi_done`=1 → STORE.
  - STORE: one cycle. Write `spi_rdData[11:0]` if index≥1. If index==NUM_CH → IDLE, pulse `irq` for 1 cycle and increment the scan count. Otherwise increment index → TRIG.
  - Timeout: if TRIG or DONE_WAIT lasts TIMEOUT cycles, drop `spi_trig`, set timeout, and go to IDLE. Results already stored are kept; no `irq` is raised.
- Clearing enable mid-scan completes the current scan; the FSM then stays in IDLE.
- Bus access:
  - `mem_ready` is high for exactly 1 cycle, the cycle after `mem_valid` is first sampled high.
  - `mem_rdata` is valid in that same cycle.
  - `mem_valid` must drop after `mem_ready`.
- A same-cycle STORE and read of the same RESULT word:
  - The read returns the old value.
  - Fresh ends up set, because the store wins.

## Timing
- Handshake latency per frame: `clk` cycles from `spi_trig` rising to `spi_done` falling (up to one SCLK half-period, about 34 `clk` at the current divider), plus the 16-SCLK frame, plus 1 STORE cycle.
- Sampling:
  - `spi_done` is sampled raw.
  - `spi_rdData` is stable once `spi_done`=1, so it is sampled in STORE, never earlier.
- `resn` low mid-frame forces IDLE on the next edge and `spi_trig`=0. A frame that is already running in `spi` completes ignored.
- Period counter: `PERIOD`≥1. With `PERIOD`=1, a scan starts in the first IDLE cycle after the previous scan ends.

## Structure
- Shared package `xoro_periph_pkg`:
  - Register indices: RESULT0, CTRL, STATUS.
  - ADC command field position: 13:11.
  - Sample width: 12.
  - FSM state encoding.
- Natural sub-module: `adc_regfile`, holding the bus decode, RESULT/CTRL/STATUS storage and the fresh/sticky bit rules. The FSM stays in `adc_scanner`.

## Test plan
- Behavioral `spi` model: the ADC returns (ch+1)*0x111 for channel ch. Enable with NUM_CH=8.
  - Required: RESULT[0..7] = 0x111..0x888, all fresh, `irq` high for 1 cycle, scan count = 1.
  - Required: exactly 9 `spi_trig` rising edges.
  - Required: `spi_wrData` of frame 3 = 0x1800.
- Read RESULT[2] twice after a scan.
  - Required: first read returns 0x80000333, second returns 0x00000333.
- Model holds `spi_done` high forever, with TIMEOUT=64.
  - Required: `spi_trig` drops after 64 cycles, STATUS bit 1 = 1, no `irq`.
  - Writing 0x2 to STATUS clears bit 1.
- Clear enable during frame 4.
  - Required: the scan finishes with all 8 results and `irq`.
  - Required: no further `spi_trig` over 2×PERIOD.
- Assert `resn`=0 during DONE_WAIT.
  - Required: next cycle `spi_trig`=0, all RESULT=0, CTRL=0.
  - Required: after release, no frame starts until enable is rewritten.
- Read index 12, and write CTRL with `mem_wstrb`=4'hF.
  - Required: the read returns 0.
  - Required: `mem_ready` pulses 1 cycle after `mem_valid` on both accesses.
